z_run_monitor: RTL and testbench
================================

Name: z_run_monitor

Overview:
- Downstream consumer of the four-in-a-row sequence detector (one-hot FSM on serial input w).
- Watches the detector's two terminal-state flags: z0 (run of 0s, state y[4]) and z1 (run of 1s, state y[8]).
- Counts distinct detection events per polarity and measures each event's length in cycles.
- Tracks the longest event and flags illegal flag combinations; results go to LEDs/HEX on the board.

Parameters:
CW, 8, width of each event counter
LW, 8, width of current/max length registers

Ports:
Clk  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
z0  input  1  detector flag, run of 0s active (detector y[4])
z1  input  1  detector flag, run of 1s active (detector y[8])
clr  input  1  synchronous clear of all statistics
run_count0  output  CW  number of completed-or-ongoing 0-runs started
run_count1  output  CW  number of 1-runs started
max_len  output  LW  longest finished run, in cycles of flag high
cur_len  output  LW  length of the run in progress (0 in IDLE)
in_run  output  1  high while state is RUN0 or RUN1
run_done  output  1  one-cycle pulse when a run ends
err  output  1  sticky; set when z0 and z1 are sampled high together

Behaviour:
- Reset (Resetn=0, async): state=IDLE; all outputs 0.
- All outputs are registered. Inputs are sampled on a rising Clk edge; effects are visible after that edge.
- States: IDLE, RUN0, RUN1. in_run = (state != IDLE).
- IDLE:
  - z0 & ~z1 -> RUN0, run_count0++, cur_len=1.
  - z1 & ~z0 -> RUN1, run_count1++, cur_len=1.
  - Otherwise stay.
- RUN0:
  - z0 & ~z1 -> stay, cur_len++.
  - Otherwise the run ends: run_done=1 for one cycle, and max_len = max(max_len, cur_len).
  - Next state after a run ends:
    - z1 & ~z0 -> RUN1, run_count1++, cur_len=1 (back-to-back runs).
    - Anything else -> IDLE, cur_len=0.
- RUN1: symmetric to RUN0 with z0/z1 swapped.
- z0 & z1 sampled high in any state:
  - err<=1 (sticky until clr or reset).
  - Treated as no flag: an active run ends as above; IDLE stays IDLE.
- Saturation:
  - run_count0/1 hold at 2^CW-1.
  - cur_len holds at 2^LW-1; max_len compares against the saturated value.
- Length semantics: a run of N equal bits (N>=4) gives cur_len/max_len = N-3.
- clr=1:
  - Next state IDLE; run_count0/1, max_len, cur_len, err, run_done all 0.
  - clr has priority over every flag in the same cycle.
  - A flag still high after clr drops starts a new run on that edge.
- run_done is never asserted in the cycle following clr or reset.
- Reset mid-run: run is discarded (no run_done, max_len not updated).

Optional Feature:
- Macro Z_RUN_HEX_EN.
- Defined:
  - Adds outputs HEX0[6:0] and HEX1[6:0], active-low seven-segment, segment order g..a in bits 6..0.
  - HEX0 shows run_count0[3:0] and HEX1 shows run_count1[3:0], hex digits 0-F.
  - Outputs are registered from the counter values: one cycle behind the counters. All segments off (7'h7F) during reset.
- Undefined: HEX ports and decode logic absent; all other behaviour identical.

Test Plan:
- Reset, then z0 high 3 cycles, then low -> run_count0=1, cur_len 1,2,3, run_done one pulse on the edge after the last high, max_len=3, in_run=0, err=0.
- z0 high 2 cycles, then z1 high 5 cycles immediately, then idle -> run_count0=1, run_count1=1, run_done pulses twice, max_len=5, no IDLE cycle between runs.
- CW=4: 17 separate 1-cycle z1 pulses separated by idle cycles -> run_count1 saturates at 15; max_len=1.
- z0 and z1 high together for 1 cycle during RUN0 (cur_len=2) -> run ends, run_done=1, max_len=2, err=1 and stays 1 through later runs until clr.
- clr asserted while in RUN1 with z1 still high, clr held 1 cycle -> all stats 0 with no run_done; on the next edge with z1 high, RUN1 entered and run_count1=1.
- Resetn dropped asynchronously mid-clock-period during RUN0 -> outputs 0 immediately without waiting for an edge; with Z_RUN_HEX_EN, HEX0=HEX1=7'h7F, then HEX0=7'h40 (digit 0) one cycle after release.

Source files
------------

// File: rtl/z_run_monitor.sv
// z_run_monitor: statistics collector for a four-in-a-row sequence detector.
// It watches the detector's terminal-state flags z0 (run of 0s) and z1 (run of 1s).
// For each polarity it counts run starts, and it tracks the current and longest run
// lengths. It also keeps a sticky error for the illegal z0&z1 combination.
// Optional build macro Z_RUN_HEX_EN adds registered seven-segment outputs HEX0/HEX1.
// These show the low nibble of each run counter.
module z_run_monitor #(
   parameter int CW = 8,
   parameter int LW = 8
) (
   input  logic          Clk,
   input  logic          Resetn,
   input  logic          z0,
   input  logic          z1,
   input  logic          clr,
   output logic [CW-1:0] run_count0,
   output logic [CW-1:0] run_count1,
   output logic [LW-1:0] max_len,
   output logic [LW-1:0] cur_len,
   output logic          in_run,
   output logic          run_done,
   output logic          err
`ifdef Z_RUN_HEX_EN
   ,
   output logic [6:0]    HEX0,
   output logic [6:0]    HEX1
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN0 = 2'b01,
      RUN1 = 2'b10
   } state_t;

   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [LW-1:0] LEN_MAX  = {LW{1'b1}};
   localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};

   state_t        state_r;
   state_t        state_s;

   // A flag counts only when it is high alone.
   // Both flags high together behave like no flag at all.
   logic          flag0_s;
   logic          flag1_s;
   logic          both_s;

   logic          start0_s;
   logic          start1_s;
   logic          ending_s;

   logic [CW-1:0] run_count0_s;
   logic [CW-1:0] run_count1_s;
   logic [LW-1:0] max_len_s;
   logic [LW-1:0] cur_len_s;
   logic          in_run_s;
   logic          run_done_s;
   logic          err_s;

   assign flag0_s = z0 & ~z1;
   assign flag1_s = z1 & ~z0;
   assign both_s  = z0 & z1;

   // State register; an async reset discards any run in progress.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state: the clean flag alone picks the state.
   // This lets a run of one polarity hand over directly to the other.
   always_comb begin
      state_s = IDLE;
      if (clr) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE, RUN0, RUN1: begin
               if (flag0_s) begin
                  state_s = RUN0;
               end else if (flag1_s) begin
                  state_s = RUN1;
               end else begin
                  state_s = IDLE;
               end
            end
            default: state_s = IDLE;
         endcase
      end
   end

   // Output next-values derived from the current and next state (clr wins over everything).
   always_comb begin
      start0_s     = (state_s == RUN0) && (state_r != RUN0);
      start1_s     = (state_s == RUN1) && (state_r != RUN1);
      ending_s     = (state_r != IDLE) && (state_s != state_r);
      run_count0_s = run_count0;
      run_count1_s = run_count1;
      max_len_s    = max_len;
      cur_len_s    = cur_len;
      in_run_s     = (state_s != IDLE);
      run_done_s   = 1'b0;
      err_s        = err;
      if (clr) begin
         run_count0_s = CNT_ZERO;
         run_count1_s = CNT_ZERO;
         max_len_s    = LEN_ZERO;
         cur_len_s    = LEN_ZERO;
         in_run_s     = 1'b0;
         run_done_s   = 1'b0;
         err_s        = 1'b0;
      end else begin
         if (start0_s && (run_count0 != CNT_MAX)) begin
            run_count0_s = run_count0 + CNT_ONE;
         end else begin
            run_count0_s = run_count0;
         end
         if (start1_s && (run_count1 != CNT_MAX)) begin
            run_count1_s = run_count1 + CNT_ONE;
         end else begin
            run_count1_s = run_count1;
         end
         // cur_len already holds the finished run's (possibly saturated) length here
         if (ending_s && (cur_len > max_len)) begin
            max_len_s = cur_len;
         end else begin
            max_len_s = max_len;
         end
         if (state_s == IDLE) begin
            cur_len_s = LEN_ZERO;
         end else if (state_s != state_r) begin
            cur_len_s = LEN_ONE;
         end else if (cur_len != LEN_MAX) begin
            cur_len_s = cur_len + LEN_ONE;
         end else begin
            cur_len_s = cur_len;
         end
         run_done_s = ending_s;
         if (both_s) begin
            err_s = 1'b1;
         end else begin
            err_s = err;
         end
      end
   end

   // Registered statistics outputs.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         run_count0 <= CNT_ZERO;
         run_count1 <= CNT_ZERO;
         max_len    <= LEN_ZERO;
         cur_len    <= LEN_ZERO;
         in_run     <= 1'b0;
         run_done   <= 1'b0;
         err        <= 1'b0;
      end else begin
         run_count0 <= run_count0_s;
         run_count1 <= run_count1_s;
         max_len    <= max_len_s;
         cur_len    <= cur_len_s;
         in_run     <= in_run_s;
         run_done   <= run_done_s;
         err        <= err_s;
      end
   end

`ifdef Z_RUN_HEX_EN
   // Active-low seven-segment glyph for one hex digit, bit order g..a.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         4'hF:    s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Display registers follow the counter registers one cycle behind; blank during reset.
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         HEX0 <= 7'h7F;
         HEX1 <= 7'h7F;
      end else begin
         HEX0 <= seg7(run_count0[3:0]);
         HEX1 <= seg7(run_count1[3:0]);
      end
   end
`else
   // No display outputs in this build.
`endif

endmodule

// File: tb/tb_z_run_monitor.sv
// Self-checking bench for z_run_monitor (small CW/LW so saturation is reachable quickly).
module tb_z_run_monitor;

   localparam int CW   = 4;
   localparam int LW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int LMAX = (1 << LW) - 1;
   localparam int VW   = 2 * CW + 2 * LW + 3;

   logic          Clk = 1'b0;
   logic          Resetn;
   logic          z0;
   logic          z1;
   logic          clr;
   logic [CW-1:0] run_count0;
   logic [CW-1:0] run_count1;
   logic [LW-1:0] max_len;
   logic [LW-1:0] cur_len;
   logic          in_run;
   logic          run_done;
   logic          err;
`ifdef Z_RUN_HEX_EN
   logic [6:0]    HEX0;
   logic [6:0]    HEX1;
`endif

   z_run_monitor #(.CW(CW), .LW(LW)) dut (
      .Clk(Clk), .Resetn(Resetn), .z0(z0), .z1(z1), .clr(clr),
      .run_count0(run_count0), .run_count1(run_count1),
      .max_len(max_len), .cur_len(cur_len),
      .in_run(in_run), .run_done(run_done), .err(err)
`ifdef Z_RUN_HEX_EN
      , .HEX0(HEX0), .HEX1(HEX1)
`endif
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;

   // Reference model: the run is "the streak of identical clean flags", tracked as plain integers
   int         m_cnt0, m_cnt1, m_max, m_streak, m_prev; // m_prev: 0 none, 1 zeros, 2 ones
   bit         m_done, m_err;
   logic [6:0] m_hex0, m_hex1;
   logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   wire [VW-1:0] dut_vec = {run_count0, run_count1, max_len, cur_len, in_run, run_done, err};

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [CW-1:0] c0, c1;
      logic [LW-1:0] mx, cl;
      c0 = CW'(m_cnt0);
      c1 = CW'(m_cnt1);
      mx = LW'(m_max);
      cl = LW'(imin(m_streak, LMAX));
      return {c0, c1, mx, cl, (m_prev != 0), m_done, m_err};
   endfunction

   task automatic model_reset();
      m_cnt0 = 0; m_cnt1 = 0; m_max = 0; m_streak = 0; m_prev = 0;
      m_done = 1'b0; m_err = 1'b0;
      m_hex0 = 7'h7F; m_hex1 = 7'h7F;
   endtask

   task automatic model_edge(input logic a, input logic b, input logic c);
      int flag;
      m_hex0 = seg_tab[m_cnt0 % 16];
      m_hex1 = seg_tab[m_cnt1 % 16];
      if (c) begin
         m_cnt0 = 0; m_cnt1 = 0; m_max = 0; m_streak = 0; m_prev = 0;
         m_done = 1'b0; m_err = 1'b0;
      end else begin
         flag = (a && !b) ? 1 : ((b && !a) ? 2 : 0);
         m_done = (m_prev != 0) && (flag != m_prev);
         if (m_done && imin(m_streak, LMAX) > m_max) m_max = imin(m_streak, LMAX);
         if (flag == 0) begin
            m_streak = 0;
         end else if (flag == m_prev) begin
            m_streak++;
         end else begin
            m_streak = 1;
            if (flag == 1) m_cnt0 = imin(m_cnt0 + 1, CMAX);
            else           m_cnt1 = imin(m_cnt1 + 1, CMAX);
         end
         m_prev = flag;
         if (a && b) m_err = 1'b1;
      end
   endtask

   task automatic drive_step(input logic a, input logic b, input logic c);
      z0 = a; z1 = b; clr = c;
      @(posedge Clk);
      model_edge(a, b, c);
      #1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0; z0 = 1'b0; z1 = 1'b0; clr = 1'b0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", dut_vec); end
`ifdef Z_RUN_HEX_EN
      checks++;
      if ({HEX0, HEX1} !== {7'h7F, 7'h7F}) begin errors++; $display("FAIL reset_hex got=%h/%h want=7f/7f", HEX0, HEX1); end
`endif
      @(negedge Clk);
      Resetn = 1'b1;
      drive_step(1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL after_reset got=%h want=%h", dut_vec, exp_vec()); end
`ifdef Z_RUN_HEX_EN
      checks++;
      if (HEX0 !== 7'h40) begin errors++; $display("FAIL hex_after_reset got=%h want=40", HEX0); end
`endif
   endtask

   task automatic test_single_run();
      drive_step(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         drive_step(1'b1, 1'b0, 1'b0);
         checks++;
         if (cur_len !== LW'(i)) begin errors++; $display("FAIL single_cur_len got=%0d want=%0d", cur_len, i); end
      end
      drive_step(1'b0, 1'b0, 1'b0);
      checks++;
      if ({run_count0, max_len, cur_len, in_run, run_done, err} !== {4'd1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL single_end cnt0=%0d max=%0d cur=%0d in_run=%b done=%b err=%b want 1 3 0 0 1 0",
                  run_count0, max_len, cur_len, in_run, run_done, err);
      end
      drive_step(1'b0, 1'b0, 1'b0);
      checks++;
      if (run_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b want=0", run_done); end
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      drive_step(1'b0, 1'b0, 1'b1);
      repeat (2) begin drive_step(1'b1, 1'b0, 1'b0); dones += int'(run_done); end
      for (int i = 0; i < 5; i++) begin
         drive_step(1'b0, 1'b1, 1'b0);
         dones += int'(run_done);
         if (i == 0) begin
            checks++;
            if ({in_run, run_done, cur_len} !== {1'b1, 1'b1, 4'd1}) begin
               errors++; $display("FAIL b2b_handover in_run=%b done=%b cur=%0d want 1 1 1", in_run, run_done, cur_len);
            end
         end
      end
      drive_step(1'b0, 1'b0, 1'b0);
      dones += int'(run_done);
      checks++;
      if ({run_count0, run_count1, max_len, in_run} !== {4'd1, 4'd1, 4'd5, 1'b0} || dones != 2) begin
         errors++;
         $display("FAIL b2b_end cnt0=%0d cnt1=%0d max=%0d in_run=%b dones=%0d want 1 1 5 0 2",
                  run_count0, run_count1, max_len, in_run, dones);
      end
   endtask

   task automatic test_saturation();
      drive_step(1'b0, 1'b0, 1'b1);
      repeat (17) begin drive_step(1'b0, 1'b1, 1'b0); drive_step(1'b0, 1'b0, 1'b0); end
      checks++;
      if ({run_count1, max_len} !== {4'd15, 4'd1}) begin
         errors++; $display("FAIL count_sat cnt1=%0d max=%0d want 15 1", run_count1, max_len);
      end
      repeat (20) drive_step(1'b1, 1'b0, 1'b0);
      checks++;
      if (cur_len !== 4'd15) begin errors++; $display("FAIL len_sat got=%0d want=15", cur_len); end
      drive_step(1'b0, 1'b0, 1'b0);
      checks++;
      if ({max_len, run_done} !== {4'd15, 1'b1}) begin
         errors++; $display("FAIL max_sat max=%0d done=%b want 15 1", max_len, run_done);
      end
   endtask

   task automatic test_error();
      drive_step(1'b0, 1'b0, 1'b1);
      repeat (2) drive_step(1'b1, 1'b0, 1'b0);
      checks++;
      if (cur_len !== 4'd2) begin errors++; $display("FAIL err_pre_len got=%0d want=2", cur_len); end
      drive_step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({run_done, max_len, err, in_run} !== {1'b1, 4'd2, 1'b1, 1'b0}) begin
         errors++; $display("FAIL err_set done=%b max=%0d err=%b in_run=%b want 1 2 1 0", run_done, max_len, err, in_run);
      end
      repeat (4) drive_step(1'b0, 1'b1, 1'b0);
      drive_step(1'b0, 1'b0, 1'b0);
      checks++;
      if ({err, max_len} !== {1'b1, 4'd4}) begin errors++; $display("FAIL err_sticky err=%b max=%0d want 1 4", err, max_len); end
      drive_step(1'b0, 1'b0, 1'b1);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b want=0", err); end
   endtask

   task automatic test_clr();
      drive_step(1'b0, 1'b0, 1'b1);
      repeat (3) drive_step(1'b0, 1'b1, 1'b0);
      drive_step(1'b0, 1'b1, 1'b1);
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL clr_zero got=%h want=0", dut_vec); end
      drive_step(1'b0, 1'b1, 1'b0);
      checks++;
      if ({in_run, run_count1, cur_len, run_done} !== {1'b1, 4'd1, 4'd1, 1'b0}) begin
         errors++; $display("FAIL clr_restart in_run=%b cnt1=%0d cur=%0d done=%b want 1 1 1 0",
                            in_run, run_count1, cur_len, run_done);
      end
   endtask

   task automatic test_async_reset();
      drive_step(1'b0, 1'b0, 1'b1);
      repeat (2) drive_step(1'b1, 1'b0, 1'b0);
      #3;
      Resetn = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL async_reset got=%h want=0", dut_vec); end
`ifdef Z_RUN_HEX_EN
      checks++;
      if ({HEX0, HEX1} !== {7'h7F, 7'h7F}) begin errors++; $display("FAIL async_hex got=%h/%h want=7f/7f", HEX0, HEX1); end
`endif
      @(negedge Clk);
      Resetn = 1'b1;
      drive_step(1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== '0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL async_release got=%h want=0", dut_vec); end
`ifdef Z_RUN_HEX_EN
      checks++;
      if (HEX0 !== 7'h40) begin errors++; $display("FAIL async_hex_release got=%h want=40", HEX0); end
`endif
   endtask

   task automatic test_random();
      int pat, len;
      logic a, b, c;
      for (int n = 0; n < 150; n++) begin
         pat = $urandom_range(0, 9);
         len = $urandom_range(1, 20);
         for (int k = 0; k < len; k++) begin
            a = (pat <= 3) || (pat == 8);
            b = (pat >= 4 && pat <= 8);
            c = ($urandom_range(0, 59) == 0);
            drive_step(a, b, c);
            checks++;
            if (dut_vec !== exp_vec()) begin
               errors++; $display("FAIL random z0=%b z1=%b clr=%b got=%h want=%h", a, b, c, dut_vec, exp_vec());
            end
`ifdef Z_RUN_HEX_EN
            checks++;
            if ({HEX0, HEX1} !== {m_hex0, m_hex1}) begin
               errors++; $display("FAIL random_hex got=%h/%h want=%h/%h", HEX0, HEX1, m_hex0, m_hex1);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_back_to_back();
      test_saturation();
      test_error();
      test_clr();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
